// File: rtl/qpsk_rx_arbiter.sv
// Grants one symbol source per character to the shared QPSK demapper and aborts on mid-character stalls.
// Optional feature macro: QPSK_ARB_FIXED_PRIO_EN (fixed lowest-index priority instead of round-robin).
module qpsk_rx_arbiter #(
  parameter int NUM_SRC       = 2,
  parameter int SYMS_PER_CHAR = 4,
  parameter int TIMEOUT       = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_SRC*8-1:0]       src_i,
  input  logic [NUM_SRC*8-1:0]       src_q,
  input  logic [NUM_SRC-1:0]         src_valid,
  output logic [NUM_SRC-1:0]         src_ready,
  input  logic                       fifo_full,
  output logic [7:0]                 sym_i,
  output logic [7:0]                 sym_q,
  output logic                       iq_valid,
  output logic [$clog2(NUM_SRC)-1:0] cur_src,
  output logic                       demap_clr,
  output logic                       sync_err
);

  localparam int SW = $clog2(NUM_SRC);
  localparam int CW = $clog2(SYMS_PER_CHAR + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, FLUSH} state_t;

  state_t              state;
  logic [SW-1:0]       last_src;
  logic [CW-1:0]       sym_cnt;
  logic [TW-1:0]       stall_cnt;
  logic                sel_valid;
  logic                xfer;
  logic signed [7:0]   sel_i;
  logic signed [7:0]   sel_q;

  function automatic logic [SW-1:0] pick_src(input logic [NUM_SRC-1:0] req,
                                             input logic [SW-1:0]      last);
    logic [SW-1:0] pick;
    int            idx;
    pick = '0;
`ifdef QPSK_ARB_FIXED_PRIO_EN
    idx = int'(last);
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (req[k]) pick = SW'(k);
    end
`else
    // Walk from lowest to highest priority so the nearest requester after last wins.
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_SRC;
      if (req[idx]) pick = SW'(idx);
    end
`endif
    return pick;
  endfunction

  assign sel_valid = src_valid[cur_src];
  assign sel_i     = src_i[int'(cur_src)*8 +: 8];
  assign sel_q     = src_q[int'(cur_src)*8 +: 8];
  assign xfer      = (state == BUSY) && sel_valid && !fifo_full;

  always_comb begin
    src_ready = '0;
    if (state == BUSY && !fifo_full) src_ready[cur_src] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cur_src   <= '0;
      last_src  <= SW'(NUM_SRC - 1);
      sym_cnt   <= '0;
      stall_cnt <= '0;
      sym_i     <= '0;
      sym_q     <= '0;
      iq_valid  <= 1'b0;
      demap_clr <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      iq_valid  <= 1'b0;
      demap_clr <= 1'b0;
      sync_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|src_valid) begin
            cur_src <= pick_src(src_valid, last_src);
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (xfer) begin
            sym_i     <= sel_i;
            sym_q     <= sel_q;
            iq_valid  <= 1'b1;
            stall_cnt <= '0;
            if (sym_cnt == CW'(SYMS_PER_CHAR - 1)) begin
              sym_cnt  <= '0;
              last_src <= cur_src;
              state    <= IDLE;
            end else begin
              sym_cnt <= sym_cnt + 1'b1;
            end
          end else if (!sel_valid && !fifo_full) begin
            // Backpressure stalls are excluded; only a silent granted source counts.
            if (stall_cnt == TW'(TIMEOUT - 1)) begin
              state     <= FLUSH;
              demap_clr <= 1'b1;
              sync_err  <= 1'b1;
            end else begin
              stall_cnt <= stall_cnt + 1'b1;
            end
          end
        end
        FLUSH: begin
          sym_cnt   <= '0;
          stall_cnt <= '0;
          last_src  <= cur_src;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
